// File: rtl/data_mem_resp_pkg.sv
// Shared types and widths for the wait-state data-memory responder.
package data_mem_resp_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_resp_wait_ctr.sv
// Loadable down-counter that times the wait states of one access; no internal latency.
// Holds at zero once reached, so the FSM can sample the zero flag at leisure.
module data_mem_resp_wait_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed SRAM on the core data port; each access completes LATENCY cycles after cen rises.
// Backpressure: mem_stall holds the core from request until the single RESP cycle.
module data_mem_responder
  import data_mem_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0100,
  parameter int          DEPTH     = 32,
  parameter int          LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_cen,
  input  logic              mem_wen,
  input  logic [31:0]       mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              mem_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state, state_nxt;
  logic              req_wen;
  logic [31:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;

  logic [WORD_W-1:0] mem [0:DEPTH-1];

  logic              acc_wen;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              enter_resp;
  logic              start;

  assign start = (state == IDLE) && mem_cen;

  // With LATENCY=1 the access completes on the accept edge, so the live inputs are used.
  assign acc_wen   = (state == IDLE) ? mem_wen   : req_wen;
  assign acc_addr  = (state == IDLE) ? mem_addr  : req_addr;
  assign acc_wdata = (state == IDLE) ? mem_wdata : req_wdata;

  assign in_range = ({1'b0, acc_addr} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, acc_addr} <  ({1'b0, BASE_ADDR} + 33'(4 * DEPTH)));
  assign idx      = IDX_W'((acc_addr - BASE_ADDR) >> 2);

  assign enter_resp = (start && (LATENCY == 1)) || ((state == WAIT) && cnt_zero);
  assign mem_stall  = start || (state == WAIT);

  data_mem_resp_wait_ctr #(.CNT_W(CNT_W)) u_wait_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start),
    .load_val (CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0)),
    .dec      (state == WAIT),
    .value    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (mem_cen) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_zero) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_wen   <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      mem_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_err <= enter_resp && !in_range;
      if (start) begin
        req_wen   <= mem_wen;
        req_addr  <= mem_addr;
        req_wdata <= mem_wdata;
      end
      if (enter_resp) begin
        if (!in_range)    mem_rdata <= '0;
        else if (!acc_wen) mem_rdata <= mem[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enter_resp && acc_wen && in_range) begin
      mem[idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus random accesses on LATENCY=2, 1 and 15 instances against a word-array reference model.
module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h0001_0100;
  localparam int          DEPTH = 32;
  localparam int          LAT [3] = '{2, 1, 15};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen_a   [3];
  logic        wen_a   [3];
  logic [31:0] addr_a  [3];
  logic [31:0] wdata_a [3];
  logic [31:0] rdata_a [3];
  logic        stall_a [3];
  logic        err_a   [3];

  logic [31:0] model_mem   [3][DEPTH];
  logic [31:0] model_rdata [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .mem_cen(cen_a[0]), .mem_wen(wen_a[0]), .mem_addr(addr_a[0]),
    .mem_wdata(wdata_a[0]), .mem_rdata(rdata_a[0]), .mem_stall(stall_a[0]), .mem_err(err_a[0]));

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .mem_cen(cen_a[1]), .mem_wen(wen_a[1]), .mem_addr(addr_a[1]),
    .mem_wdata(wdata_a[1]), .mem_rdata(rdata_a[1]), .mem_stall(stall_a[1]), .mem_err(err_a[1]));

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(15)) u_l15 (
    .clk(clk), .rst_n(rst_n), .mem_cen(cen_a[2]), .mem_wen(wen_a[2]), .mem_addr(addr_a[2]),
    .mem_wdata(wdata_a[2]), .mem_rdata(rdata_a[2]), .mem_stall(stall_a[2]), .mem_err(err_a[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      model_rdata[k] = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[k][i] = '0;
    end
  endtask

  // One core access; called just after a posedge, returns just after the edge leaving RESP.
  task automatic access(input int k, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit corrupt, input bit idle_after);
    int          stalls;
    longint      a;
    bit          inr;
    int          idx;
    logic        exp_err;
    cen_a[k] = 1'b1; wen_a[k] = wen; addr_a[k] = addr; wdata_a[k] = wdata;
    stalls = 0;
    while (stalls < 40) begin
      @(negedge clk);
      if (!stall_a[k]) break;
      stalls++;
      @(posedge clk); #1;
      if (corrupt && stalls == 1) begin
        addr_a[k]  = BASE + 32'd8;
        wdata_a[k] = 32'h5;
      end
    end
    a   = longint'(addr);
    inr = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
    idx = int'((a - longint'(BASE)) / 4);
    exp_err = !inr;
    if (!inr)      model_rdata[k] = '0;
    else if (wen)  model_mem[k][idx] = wdata;
    else           model_rdata[k] = model_mem[k][idx];
    check("stall_cycles", stalls, LAT[k]);
    check("resp_rdata", rdata_a[k], model_rdata[k]);
    check("resp_err", {31'b0, err_a[k]}, {31'b0, exp_err});
    @(posedge clk); #1;
    cen_a[k] = 1'b0;
    if (idle_after) begin
      @(negedge clk);
      check("idle_err", {31'b0, err_a[k]}, 32'd0);
      check("idle_stall", {31'b0, stall_a[k]}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return BASE - 32'(4 * $urandom_range(1, 4));
    if (r == 1) return BASE + 32'd128 + 32'(4 * $urandom_range(0, 3));
    return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cen_a[k] = 1'b0; wen_a[k] = 1'b0; addr_a[k] = '0; wdata_a[k] = '0;
    end
    model_reset();
    #2;
    check("rst_stall", {31'b0, stall_a[0]}, 32'd0);
    check("rst_rdata", rdata_a[0], 32'd0);
    check("rst_err", {31'b0, err_a[0]}, 32'd0);
    check("rst_mem5", u_l2.mem[5], 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read back
    access(0, 1'b1, 32'h0001_0104, 32'hDEAD_BEEF, 1'b0, 1'b1);
    access(0, 1'b0, 32'h0001_0104, 32'h0, 1'b0, 1'b1);
    check("t1_rdata", rdata_a[0], 32'hDEAD_BEEF);

    // Out-of-range both sides of the window
    access(0, 1'b0, 32'h0001_0180, 32'h0, 1'b0, 1'b1);
    access(0, 1'b1, 32'h0001_00FC, 32'h1234_5678, 1'b0, 1'b1);
    check("t2_mem0", u_l2.mem[0], model_mem[0][0]);
    check("t2_mem31", u_l2.mem[31], model_mem[0][31]);

    // Back-to-back without a bubble
    access(0, 1'b1, BASE, 32'h11, 1'b0, 1'b0);
    access(0, 1'b0, BASE, 32'h0, 1'b0, 1'b1);
    check("t3_rdata", rdata_a[0], 32'h11);

    // Input changes during WAIT are ignored
    access(0, 1'b1, BASE + 32'd12, 32'h99, 1'b1, 1'b1);
    check("t4_mem2", u_l2.mem[2], 32'h0);
    check("t4_mem3", u_l2.mem[3], 32'h99);

    repeat (30) begin
      access(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b0, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH; i++) check("rand_mem", u_l2.mem[i], model_mem[0][i]);

    // Reset while a write is waiting
    cen_a[0] = 1'b1; wen_a[0] = 1'b1; addr_a[0] = BASE + 32'd4; wdata_a[0] = 32'hCAFE;
    @(posedge clk); #1;
    rst_n = 1'b0;
    cen_a[0] = 1'b0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("t5_mem1", u_l2.mem[1], 32'd0);
    check("t5_stall", {31'b0, stall_a[0]}, 32'd0);
    check("t5_rdata", rdata_a[0], 32'd0);
    check("t5_err", {31'b0, err_a[0]}, 32'd0);
    @(posedge clk); #1;
    access(0, 1'b0, BASE + 32'd4, 32'h0, 1'b0, 1'b1);

    // Latency extremes
    repeat (10) begin
      access(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b0, 1'($urandom_range(0, 1)));
    end
    repeat (5) begin
      access(2, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b0, 1'b1);
    end
    access(1, 1'b0, rand_addr(), 32'h0, 1'b0, 1'b1);
    access(2, 1'b0, rand_addr(), 32'h0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
